// File: rtl/demo_input_pkg.sv
// rtl/demo_input_pkg.sv - shared state encoding and reset levels for the demo input front end
package demo_input_pkg;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    LATCH    = 2'd2,
    FIRE     = 2'd3
  } start_state_t;

  // Stable values the debouncers assume out of reset; a button reads as pressed
  // so a press held through reset is never mistaken for a new one.
  localparam logic BTN_RST_LEVEL = 1'b0;
  localparam logic SW_RST_LEVEL  = 1'b0;

  function automatic logic calc_busy(input logic d1_en, input logic d1_ready,
                                     input logic d2_en, input logic d2_ready);
    return (d1_en & ~d1_ready) | (d2_en & ~d2_ready);
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchroniser plus counter-based debounce for one raw input
module input_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RST_LEVEL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int DB_CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_CNT_WIDTH-1:0] CNT_LAST = DB_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                    sync_q1;
  logic                    sync_q2;
  logic                    stable;
  logic [DB_CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= RST_LEVEL;
      sync_q2 <= RST_LEVEL;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  // Any single cycle of agreement restarts the count, so short glitches never flip stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= RST_LEVEL;
      cnt    <= '0;
    end else if (sync_q2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= ~stable;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign dout = stable;

endmodule

// File: rtl/demo_input_ctrl.sv
// rtl/demo_input_ctrl.sv - debounced start button and latched per-master switches for the demo top
module demo_input_ctrl
  import demo_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PRESS_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_start_n,
  input  logic                       sw_d1_mode,
  input  logic                       sw_d2_mode,
  input  logic                       sw_d1_en,
  input  logic                       sw_d2_en,
  input  logic                       d1_ready,
  input  logic                       d2_ready,
  output logic                       start,
  output logic                       d1_mode,
  output logic                       d2_mode,
  output logic                       d1_en,
  output logic                       d2_en,
  output logic [PRESS_CNT_WIDTH-1:0] press_count,
  output logic                       rejected
);

  logic btn_db;
  logic d1_mode_db;
  logic d2_mode_db;
  logic d1_en_db;
  logic d2_en_db;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_LEVEL(BTN_RST_LEVEL)) u_db_btn (
    .clk (clk), .rst (rst), .din (btn_start_n), .dout (btn_db)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_LEVEL(SW_RST_LEVEL)) u_db_d1_mode (
    .clk (clk), .rst (rst), .din (sw_d1_mode), .dout (d1_mode_db)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_LEVEL(SW_RST_LEVEL)) u_db_d2_mode (
    .clk (clk), .rst (rst), .din (sw_d2_mode), .dout (d2_mode_db)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_LEVEL(SW_RST_LEVEL)) u_db_d1_en (
    .clk (clk), .rst (rst), .din (sw_d1_en), .dout (d1_en_db)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_LEVEL(SW_RST_LEVEL)) u_db_d2_en (
    .clk (clk), .rst (rst), .din (sw_d2_en), .dout (d2_en_db)
  );

  start_state_t state;
  logic         btn_prev;
  logic         btn_fall;
  logic         busy;

  assign btn_fall = btn_prev & ~btn_db;
  assign busy     = calc_busy(d1_en, d1_ready, d2_en, d2_ready);

  // Switch values are captured on entry to LATCH so they sit still for a full
  // cycle before start falls; FIRE then drives the single low cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_REL;
      btn_prev    <= BTN_RST_LEVEL;
      start       <= 1'b1;
      rejected    <= 1'b0;
      d1_mode     <= 1'b0;
      d2_mode     <= 1'b0;
      d1_en       <= 1'b0;
      d2_en       <= 1'b0;
      press_count <= '0;
    end else begin
      btn_prev <= btn_db;
      start    <= 1'b1;
      rejected <= 1'b0;
      case (state)
        WAIT_REL: begin
          if (btn_db) state <= IDLE;
        end
        IDLE: begin
          if (btn_fall) begin
            if (busy) begin
              rejected <= 1'b1;
              state    <= WAIT_REL;
            end else begin
              d1_mode <= d1_mode_db;
              d2_mode <= d2_mode_db;
              d1_en   <= d1_en_db;
              d2_en   <= d2_en_db;
              state   <= LATCH;
            end
          end
        end
        LATCH: begin
          start       <= 1'b0;
          press_count <= press_count + 1'b1;
          state       <= FIRE;
        end
        FIRE: begin
          state <= WAIT_REL;
        end
        default: state <= WAIT_REL;
      endcase
    end
  end

endmodule
